rf_arbiter2: RTL

Two-port arbiter and sequencer for the 32-entry × 256-bit register-file cache macro (registered read data, active-low write enable). It owns the macro's address, data and write-enable pins and zero-fills all entries after reset. It then shares the single RF port between two requesters using a valid/ready handshake. Each accepted access returns a one-cycle-latency response to the port that issued it.

---
 rtl/rf_arbiter2.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/rf_arbiter2.sv
// Two-port valid/ready arbiter and sequencer for a 32x256 register-file cache macro.
// Zero-fills the macro after reset; `define RF_ARB_RR_EN for round-robin, else fixed priority (port 0).
module rf_arbiter2 #(
  parameter int AW = 5,
  parameter int DW = 256
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic          req0_we,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_wdata,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic          req1_we,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_wdata,
  output logic          rsp0_valid,
  output logic [DW-1:0] rsp0_rdata,
  output logic          rsp1_valid,
  output logic [DW-1:0] rsp1_rdata,
  output logic          init_done,
  output logic [AW-1:0] rf_a,
  output logic [DW-1:0] rf_d,
  output logic          rf_wen,
  input  logic [DW-1:0] rf_q
);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t        r_state;
  logic [AW-1:0] r_cnt;
  logic          r_rsp_pend;
  logic          r_rsp_sel;
  logic          w_run;
  logic          w_gnt0;
  logic          w_gnt1;

`ifdef RF_ARB_RR_EN
  logic          r_prio;

  // Round-robin pointer: favour the port that was not granted last.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prio <= 1'b0;
    end else if (w_gnt0) begin
      r_prio <= 1'b1;
    end else if (w_gnt1) begin
      r_prio <= 1'b0;
    end else begin
      r_prio <= r_prio;
    end
  end
`endif

  // Grant decision; readiness depends only on valids and the priority state.
  always_comb begin
    w_run  = (r_state == ST_RUN) && !rst;
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (w_run) begin
`ifdef RF_ARB_RR_EN
      if (req0_valid && req1_valid) begin
        w_gnt0 = !r_prio;
        w_gnt1 = r_prio;
      end else begin
        w_gnt0 = req0_valid;
        w_gnt1 = req1_valid;
      end
`else
      w_gnt0 = req0_valid;
      w_gnt1 = req1_valid && !req0_valid;
`endif
    end else begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
    end
  end

  // RF pin mux: zero-fill, granted access, or idle read of entry 0.
  always_comb begin
    rf_a   = {AW{1'b0}};
    rf_d   = {DW{1'b0}};
    rf_wen = 1'b1;
    if (rst) begin
      rf_wen = 1'b1;
    end else if (r_state == ST_INIT) begin
      rf_a   = r_cnt;
      rf_wen = 1'b0;
    end else if (w_gnt0) begin
      rf_a   = req0_addr;
      rf_d   = req0_wdata;
      rf_wen = !req0_we;
    end else if (w_gnt1) begin
      rf_a   = req1_addr;
      rf_d   = req1_wdata;
      rf_wen = !req1_we;
    end else begin
      rf_wen = 1'b1;
    end
  end

  // Sequencer state and response tracking; the fill counter stops at the last entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_INIT;
      r_cnt      <= {AW{1'b0}};
      r_rsp_pend <= 1'b0;
      r_rsp_sel  <= 1'b0;
    end else begin
      case (r_state)
        ST_INIT: begin
          if (r_cnt == {AW{1'b1}}) begin
            r_state <= ST_RUN;
          end else begin
            r_cnt <= r_cnt + {{(AW-1){1'b0}}, 1'b1};
          end
        end
        ST_RUN: begin
          r_state <= ST_RUN;
        end
        default: begin
          r_state <= ST_INIT;
        end
      endcase
      r_rsp_pend <= w_gnt0 || w_gnt1;
      r_rsp_sel  <= w_gnt1;
    end
  end

  assign req0_ready = w_gnt0;
  assign req1_ready = w_gnt1;
  assign init_done  = w_run;
  assign rsp0_valid = !rst && r_rsp_pend && !r_rsp_sel;
  assign rsp1_valid = !rst && r_rsp_pend && r_rsp_sel;
  assign rsp0_rdata = rf_q;
  assign rsp1_rdata = rf_q;

endmodule
